// File: rtl/neuron_fixed_pkg.sv
// Purpose : shared Q12.9 fixed-point types and constants for the digital-neuron datapath.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package neuron_fixed_pkg;

   localparam int W    = 21;   // total signed width
   localparam int FRAC = 9;    // fractional bits (Q12.9)

   typedef logic signed [W-1:0] fixed_t;

   // 30.0 and -65.0 in Q12.9 (scaled by 2^FRAC).
   localparam fixed_t V_PEAK          = fixed_t'(30 * (1 << FRAC));   //  15360
   localparam fixed_t C_RESET_DEFAULT = fixed_t'(-65 * (1 << FRAC));  // -33280

endpackage

// File: rtl/mux_vsel_if.sv
// Purpose : groups the candidate-potential input bus and the selected-potential output bus.
// Latency : n/a (wiring only).
// Backpressure: none; producer may present a sample every cycle.
// Ports   : in_valid/v_in/c_in driven by the producer (master),
//           v_out/spike/out_valid driven by the selector (slave).
interface mux_vsel_if;
   import neuron_fixed_pkg::*;

   logic   in_valid;
   fixed_t v_in;
   fixed_t c_in;
   fixed_t v_out;
   logic   spike;
   logic   out_valid;

   modport master (
      output in_valid, v_in, c_in,
      input  v_out, spike, out_valid
   );

   modport slave (
      input  in_valid, v_in, c_in,
      output v_out, spike, out_valid
   );

endinterface

// File: rtl/vsel_core.sv
// Purpose : combinational spike test and reset-voltage select.
// Latency : 0 cycles (purely combinational).
// Backpressure: none.
// Ports   : v_in/c_in candidate and reset voltages; sel_v selected voltage; is_spike threshold hit.
module vsel_core
   import neuron_fixed_pkg::*;
(
   input  fixed_t v_in,
   input  fixed_t c_in,
   output fixed_t sel_v,
   output logic   is_spike
);

   // Both operands are signed fixed_t, so this is a true two's-complement
   // compare; reaching the peak exactly counts as a spike.
   assign is_spike = (v_in >= V_PEAK);
   assign sel_v    = is_spike ? c_in : v_in;

endmodule

// File: rtl/mux_vsel.sv
// Purpose : spike-reset voltage selector between the v-update arithmetic and the membrane register.
// Latency : 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts one sample per cycle.
// Ports   : clk, rst_n (async active-low); bus.slave carries in_valid/v_in/c_in in,
//           v_out/spike/out_valid out (all outputs registered).
module mux_vsel
   import neuron_fixed_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   mux_vsel_if.slave  bus
);

   fixed_t sel_v;
   logic   is_spike;

   vsel_core u_core (
      .v_in     (bus.v_in),
      .c_in     (bus.c_in),
      .sel_v    (sel_v),
      .is_spike (is_spike)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.v_out     <= '0;
         bus.spike     <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         // spike is a one-cycle qualifier, never left high on idle cycles.
         bus.spike     <= bus.in_valid & is_spike;
         // v_out keeps the last selected value while the input is idle.
         if (bus.in_valid) begin
            bus.v_out <= sel_v;
         end
      end
   end

endmodule

// File: tb/tb_mux_vsel.sv
module tb_mux_vsel;
   import neuron_fixed_pkg::*;

   logic clk;
   logic rst_n;

   mux_vsel_if bus ();

   mux_vsel dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int   v;
      logic spk;
   } exp_t;

   exp_t exp_q[$];
   int   hold_v = 0;   // value v_out must hold on idle cycles

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result,
   // and checks idle behaviour otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("v_out", int'($signed(bus.v_out)), e.v);
               chk("spike", int'(bus.spike), int'(e.spk));
               hold_v = e.v;
            end
         end else begin
            chk("idle_spike", int'(bus.spike), 0);
            chk("idle_v_hold", int'($signed(bus.v_out)), hold_v);
         end
      end
   end

   // Directed vectors: v_in, c_in, hand-computed v_out, spike.
   localparam int NV = 9;
   int   tv_v  [NV] = '{ 10240,  25600, -40960,  15360, 15359, -1048576, 1048575, 15360, 0};
   int   tv_c  [NV] = '{-33280, -33280, -33280, -33280, -33280, -33280,  -33280, 20000, 5};
   int   tv_ev [NV] = '{ 10240, -33280, -40960, -33280, 15359, -1048576, -33280, 20000, 0};
   logic tv_es [NV] = '{ 1'b0,   1'b1,   1'b0,   1'b1,  1'b0,   1'b0,     1'b1,  1'b1, 1'b0};

   task automatic send(input int v, input int c, input int ev, input logic es);
      exp_t e;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.v_in     = fixed_t'(v);
      bus.c_in     = fixed_t'(c);
      e.v   = ev;
      e.spk = es;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.v_in     = fixed_t'(12345);
         bus.c_in     = fixed_t'(-7);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.v_in     = '0;
      bus.c_in     = '0;
      #1;
      chk("reset_v_out",     int'($signed(bus.v_out)), 0);
      chk("reset_spike",     int'(bus.spike), 0);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      #20;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back directed samples, first burst of eight.
      for (int i = 0; i < NV - 1; i++) send(tv_v[i], tv_c[i], tv_ev[i], tv_es[i]);
      idle(3);
      send(tv_v[NV-1], tv_c[NV-1], tv_ev[NV-1], tv_es[NV-1]);
      idle(2);

      // Spiking sample in flight when reset is asserted between edges.
      send(1048575, 777, 777, 1'b1);
      @(posedge clk);   // sample captured, result now visible
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      hold_v = 0;
      #1;
      chk("midreset_v_out",     int'($signed(bus.v_out)), 0);
      chk("midreset_spike",     int'(bus.spike), 0);
      chk("midreset_out_valid", int'(bus.out_valid), 0);
      // Input still valid across an edge while in reset: must be discarded.
      bus.v_in = fixed_t'(20000);
      @(posedge clk);
      #1;
      chk("inreset_out_valid", int'(bus.out_valid), 0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      idle(2);
      send(-5, 100, -5, 1'b0);
      idle(3);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
